// File: rtl/tdm_demux_pkg.sv
// Shared types for the 1-to-4 TDM demultiplexer: FSM states, slot count and slot index.
package tdm_demux_pkg;

    typedef enum logic {
        HUNT   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    localparam int SLOTS = 4;

    typedef logic [1:0] slot_t;

endpackage

// File: rtl/tdm_slot_ctr.sv
// Modulo-4 slot counter. load0 marks a beat taken as slot 0, so the next beat is slot 1.
module tdm_slot_ctr
    import tdm_demux_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       inc,
    input  logic       load0,
    output logic [1:0] slot
);

    always_ff @(posedge clk) begin
        if (rst) begin
            slot <= '0;
        end else if (load0) begin
            slot <= slot_t'(1);
        end else if (inc) begin
            slot <= slot + 2'd1;
        end
    end

endmodule

// File: rtl/tdm_demux_1to4.sv
// 1-to-4 TDM demultiplexer with sof-based frame alignment (HUNT/LOCKED).
// Optional feature: define TDM_SYNC_ERR_EN to drive the sync_err misalignment pulse.
module tdm_demux_1to4 #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    input  logic             sof,
    output logic [WIDTH-1:0] f0,
    output logic [WIDTH-1:0] f1,
    output logic [WIDTH-1:0] f2,
    output logic [WIDTH-1:0] f3,
    output logic             frame_valid,
    output logic             sync_err,
    output logic             fsm_state
);
    import tdm_demux_pkg::*;

    state_t           state;
    state_t           state_nxt;
    logic [1:0]       slot;
    logic             load0;
    logic             inc;
    logic             frame_done;
    logic [WIDTH-1:0] shadow [SLOTS-1];

    assign fsm_state = state;

    tdm_slot_ctr u_slot_ctr (
        .clk   (clk),
        .rst   (rst),
        .inc   (inc),
        .load0 (load0),
        .slot  (slot)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= HUNT;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        load0      = 1'b0;
        inc        = 1'b0;
        frame_done = 1'b0;
        if (din_valid) begin
            case (state)
                HUNT: begin
                    if (sof) begin
                        load0     = 1'b1;
                        state_nxt = LOCKED;
                    end
                end
                LOCKED: begin
                    // sof always restarts the frame; a missing sof at slot 0 loses lock
                    if (sof) begin
                        load0 = 1'b1;
                    end else if (slot == 2'd0) begin
                        state_nxt = HUNT;
                    end else begin
                        inc        = 1'b1;
                        frame_done = (slot == 2'd3);
                    end
                end
                default: state_nxt = HUNT;
            endcase
        end
    end

    // Slot 3 goes straight to f3, so only slots 0..2 need a shadow register.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < SLOTS - 1; i++) begin
                shadow[i] <= '0;
            end
            f0          <= '0;
            f1          <= '0;
            f2          <= '0;
            f3          <= '0;
            frame_valid <= 1'b0;
        end else begin
            frame_valid <= frame_done;
            if (load0) begin
                shadow[0] <= din;
            end else if (inc) begin
                for (int i = 1; i < SLOTS - 1; i++) begin
                    if (slot == slot_t'(i)) begin
                        shadow[i] <= din;
                    end
                end
            end
            if (frame_done) begin
                f0 <= shadow[0];
                f1 <= shadow[1];
                f2 <= shadow[2];
                f3 <= din;
            end
        end
    end

`ifdef TDM_SYNC_ERR_EN
    logic err_evt;

    always_comb begin
        err_evt = 1'b0;
        if (din_valid && state == LOCKED) begin
            err_evt = sof ? (slot != 2'd0) : (slot == 2'd0);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_err <= 1'b0;
        end else begin
            sync_err <= err_evt;
        end
    end
`else
    assign sync_err = 1'b0;
`endif

endmodule

// File: doc/tdm_demux_1to4.md
TDM_DEMUX_1TO4 -- requirements
Module: tdm_demux_1to4

Interface
REQ-001 SHALL have parameter WIDTH, default 8, giving the data width of each slot.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates occur on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-004 SHALL have port din, input, WIDTH bits: the time-multiplexed data beat.
REQ-005 SHALL have port din_valid, input, 1 bit: din carries a beat this cycle.
REQ-006 SHALL have port sof, input, 1 bit: start of frame; qualified by din_valid and marks slot 0.
REQ-007 SHALL have ports f0, f1, f2, f3, output, WIDTH bits each: registered slot 0..3 data of the last complete frame.
REQ-008 SHALL have port frame_valid, output, 1 bit: a one-cycle pulse when f0..f3 update.
REQ-009 SHALL have port sync_err, output, 1 bit: a one-cycle pulse on frame misalignment.

Function
REQ-010 SHALL implement two states: HUNT and LOCKED.
REQ-011 HUNT: SHALL discard beats without sof; a beat with sof SHALL be captured as slot 0, set slot to 1 and move to LOCKED.
REQ-012 LOCKED: each accepted beat SHALL be stored in shadow[slot], and slot SHALL increment, wrapping 3->0.
REQ-013 LOCKED: a beat with slot==0 and sof=1 SHALL start a new frame normally.
REQ-014 LOCKED: a beat with slot==0 and sof=0 SHALL be discarded, and the block SHALL return to HUNT.
REQ-015 LOCKED: a beat with sof=1 at slot 1..3 SHALL discard the partial frame and be captured as slot 0, with slot set to 1 and the state staying LOCKED.
REQ-016 On acceptance of the slot-3 beat, f0..f3 SHALL load shadow[0..2] and din together; frame_valid SHALL be 1 on the next cycle only; latency is 1 clk from the slot-3 beat.
REQ-017 f0..f3 SHALL hold their values between frames; a partial frame SHALL never reach the outputs.
REQ-018 Cycles with din_valid=0 SHALL change no state; gaps between beats of any length SHALL be allowed.
REQ-019 Back-to-back frames with din_valid held high SHALL give one frame_valid every 4 cycles.
REQ-020 Slot arithmetic SHALL be 2-bit unsigned, modulo 4.

Reset
REQ-021 While rst=1: state=HUNT, slot=0, shadow=0, f0..f3=0, frame_valid=0, sync_err=0.
REQ-022 rst SHALL take priority over din_valid; a frame in progress SHALL be dropped with no frame_valid.
REQ-023 The first beat SHALL be accepted on the first clk edge with rst=0.

Configuration
REQ-024 With macro TDM_SYNC_ERR_EN defined, sync_err SHALL pulse for one cycle, the cycle after each event under REQ-014 or REQ-015.
REQ-025 Without TDM_SYNC_ERR_EN, sync_err SHALL be tied 0, no logic SHALL drive it, and all other behaviour SHALL be identical.

Structure
REQ-026 Package tdm_demux_pkg SHALL hold the state enum (HUNT, LOCKED), the constant SLOTS=4 and the 2-bit slot index typedef.
REQ-027 The slot counter SHALL be sub-module tdm_slot_ctr, with inputs clk, rst, inc, load0 and output slot.

Verification
REQ-028 Reset then beats 0x11(sof), 0x22, 0x33, 0x44 -> one cycle after 0x44: f0..f3 = 11,22,33,44 and frame_valid=1 for 1 cycle.
REQ-029 Beats 0xAA, 0xBB without sof in HUNT, then the frame of REQ-028 -> same result as REQ-028; AA and BB never appear on the outputs.
REQ-030 Frame 0x01(sof), 0x02, then 0x05(sof), 0x06, 0x07, 0x08 -> f = 05,06,07,08; sync_err=1 once when EN is defined, 0 otherwise.
REQ-031 Two frames with din_valid held high -> frame_valid pulses exactly 4 cycles apart; the second frame's values appear.
REQ-032 rst=1 after slot 2 of a frame, then the frame of REQ-028 -> all outputs 0 during reset, no frame_valid, then REQ-028 values.
REQ-033 Frame with din_valid=0 gaps of 3 cycles between beats -> same outputs as REQ-028; frame_valid 1 cycle after the last beat.
